// File: rtl/smoldvi_tmds_rx_lane_if.sv
// Purpose : receive-lane bus for smoldvi_tmds_rx_lane.
// Signals : din       - two serial bits per bit clock, din[0] earliest
//           sym_valid - one-cycle pulse per decoded symbol while locked
//           sym_raw   - aligned 10-bit symbol, bit 0 received first
//           is_ctrl   - sym_raw is a TMDS control symbol
//           ctrl      - control code {C1,C0}
//           data      - decoded data byte
//           locked    - symbol alignment acquired
//           offset    - current bit offset of the symbol window (0..9)
// Modports: master = the receive lane, slave = the consumer / stimulus side.
interface smoldvi_tmds_rx_lane_if;
    logic [1:0] din;
    logic       sym_valid;
    logic [9:0] sym_raw;
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] offset;

    modport master (
        input  din,
        output sym_valid, sym_raw, is_ctrl, ctrl, data, locked, offset
    );

    modport slave (
        output din,
        input  sym_valid, sym_raw, is_ctrl, ctrl, data, locked, offset
    );
endinterface

// File: rtl/smoldvi_tmds_rx_lane.sv
// Purpose : single-lane TMDS receiver. Shifts in 2 bits per clk_bit, hunts
//           for control symbols to find 10-bit alignment, then decodes each
//           symbol to a data byte or a control code.
// Ports   : clk_bit   - bit clock (5x pixel rate)
//           rst_n_bit - asynchronous active-low reset
//           bus       - smoldvi_tmds_rx_lane_if.master (din in, decoded out)
module smoldvi_tmds_rx_lane #(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned MAX_GAP    = 1024
) (
    input  logic                          clk_bit,
    input  logic                          rst_n_bit,
    smoldvi_tmds_rx_lane_if.master        bus
);
    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned GAP_W = $clog2(MAX_GAP + 2);

    typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [19:0]        r_hist;
    logic [2:0]         r_phase;
    logic [3:0]         r_offset, w_offset_nxt;
    logic [RUN_W-1:0]   r_ctrl_run, w_ctrl_run_nxt, w_run_inc;
    logic [GAP_W-1:0]   r_gap_ctr, w_gap_ctr_nxt, w_gap_inc;
    logic               w_strobe, w_gap_over, w_valid_nxt;
    logic [9:0]         w_win;
    logic               w_is_ctrl;
    logic [1:0]         w_ctrl;
    logic [7:0]         w_data;

    logic               r_sym_valid, r_is_ctrl, r_locked;
    logic [9:0]         r_sym_raw;
    logic [1:0]         r_ctrl;
    logic [7:0]         r_data;

    // DVI 1.0 TMDS data decode
    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] b;
        logic [7:0] d;
        b    = q[9] ? ~q[7:0] : q[7:0];
        d    = 8'd0;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

    assign w_strobe   = (r_phase == 3'd4);
    assign w_win      = 10'(r_hist >> r_offset);
    assign w_run_inc  = (r_ctrl_run == RUN_W'(LOCK_COUNT)) ? r_ctrl_run : r_ctrl_run + RUN_W'(1);
    assign w_gap_inc  = r_gap_ctr + GAP_W'(1);
    assign w_gap_over = (w_gap_inc > GAP_W'(MAX_GAP));
    assign w_data     = tmds_decode(w_win);

    // Control symbol classification
    always_comb begin
        w_is_ctrl = 1'b1;
        w_ctrl    = 2'd0;
        case (w_win)
            10'h354: w_ctrl = 2'd0;
            10'h0AB: w_ctrl = 2'd1;
            10'h154: w_ctrl = 2'd2;
            10'h2AB: w_ctrl = 2'd3;
            default: w_is_ctrl = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_bit or negedge rst_n_bit) begin
        if (!rst_n_bit) r_state <= S_SEARCH;
        else            r_state <= w_state_nxt;
    end

    // FSM next state: only strobes can move it
    always_comb begin
        w_state_nxt = r_state;
        if (w_strobe) begin
            case (r_state)
                S_SEARCH: if (w_is_ctrl && (w_run_inc == RUN_W'(LOCK_COUNT))) w_state_nxt = S_LOCKED;
                S_LOCKED: if (!w_is_ctrl && w_gap_over)                      w_state_nxt = S_SEARCH;
                default:  w_state_nxt = S_SEARCH;
            endcase
        end
    end

    // FSM outputs: counter/offset updates and symbol-valid decision
    always_comb begin
        w_ctrl_run_nxt = r_ctrl_run;
        w_gap_ctr_nxt  = r_gap_ctr;
        w_offset_nxt   = r_offset;
        w_valid_nxt    = 1'b0;
        if (w_strobe) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_is_ctrl) begin
                        w_ctrl_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_W'(LOCK_COUNT)) begin
                            w_gap_ctr_nxt = '0;
                            w_valid_nxt   = 1'b1;
                        end
                    end else begin
                        // slip one bit; symbols lost across the 9->0 wrap are dropped
                        w_ctrl_run_nxt = '0;
                        w_offset_nxt   = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    end
                end
                S_LOCKED: begin
                    if (w_is_ctrl) begin
                        w_gap_ctr_nxt = '0;
                        w_valid_nxt   = 1'b1;
                    end else begin
                        w_gap_ctr_nxt = w_gap_inc;
                        if (w_gap_over) w_ctrl_run_nxt = '0;
                        else            w_valid_nxt    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_bit or negedge rst_n_bit) begin
        if (!rst_n_bit) begin
            r_hist      <= '0;
            r_phase     <= '0;
            r_offset    <= '0;
            r_ctrl_run  <= '0;
            r_gap_ctr   <= '0;
            r_sym_valid <= 1'b0;
            r_sym_raw   <= '0;
            r_is_ctrl   <= 1'b0;
            r_ctrl      <= '0;
            r_data      <= '0;
            r_locked    <= 1'b0;
        end else begin
            r_hist      <= {bus.din, r_hist[19:2]};
            r_phase     <= w_strobe ? 3'd0 : r_phase + 3'd1;
            r_offset    <= w_offset_nxt;
            r_ctrl_run  <= w_ctrl_run_nxt;
            r_gap_ctr   <= w_gap_ctr_nxt;
            r_sym_valid <= w_valid_nxt;
            r_locked    <= (w_state_nxt == S_LOCKED);
            if (w_strobe) begin
                r_sym_raw <= w_win;
                r_is_ctrl <= w_is_ctrl;
                r_ctrl    <= w_ctrl;
                r_data    <= w_data;
            end
        end
    end

    assign bus.sym_valid = r_sym_valid;
    assign bus.sym_raw   = r_sym_raw;
    assign bus.is_ctrl   = r_is_ctrl;
    assign bus.ctrl      = r_ctrl;
    assign bus.data      = r_data;
    assign bus.locked    = r_locked;
    assign bus.offset    = r_offset;
endmodule

// File: doc/smoldvi_tmds_rx_lane.md
# smoldvi_tmds_rx_lane

Single-lane TMDS receiver: the receive-side counterpart of the SmolDVI transmit path. It takes the 2-bits-per-cycle serial stream, as presented by a DDR input register in the clk_bit domain at 5x pixel rate, and recovers 10-bit symbol alignment by hunting for TMDS control symbols. It then decodes each symbol to 8-bit data or a 2-bit control code. It is used for loopback self-test of the transmitter and as the per-channel front end of a future DVI sink.

## Interface
- `LOCK_COUNT`, default 8: consecutive control symbols at one alignment required to declare lock.
- `MAX_GAP`, default 1024: maximum number of consecutive non-control symbols tolerated while locked.
- `clk_bit` input, 1 bit: bit clock, 5x the pixel rate.
- `rst_n_bit` input, 1 bit: reset, asynchronous, active-low; clock is clk_bit.
- `din` input, 2 bits: serial bits received this cycle. din[0] is the earlier bit in time; TMDS bits arrive LSB first.
- `sym_valid` output, 1 bit: one-cycle pulse per decoded symbol, only while locked.
- `sym_raw` output, 10 bits: aligned raw symbol, bit 0 = first received.
- `is_ctrl` output, 1 bit: sym_raw is one of the four control symbols.
- `ctrl` output, 2 bits: decoded control code {C1,C0}; valid when is_ctrl=1.
- `data` output, 8 bits: decoded data byte; valid when is_ctrl=0.
- `locked` output, 1 bit: alignment acquired.
- `offset` output, 4 bits: current bit offset of the symbol window, 0..9, for debug.

## Operation
- History register, 20 bits: each cycle `hist <= {din, hist[19:2]}`. hist[0] holds the oldest bit.
- Phase counter, 0..4: increments every cycle and wraps 4→0. A strobe occurs when phase==4, giving one symbol per 5 cycles. The cadence never changes, including across slips.
- Window at each strobe: `win = hist[offset +: 10]`.
- Control symbol map:
  - 0x354 → 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
  - Any other value is a data symbol.
- Data decode, per DVI 1.0:
  - If q[9]=1, invert q[7:0] first.
  - d[0] = q[0].
  - For i = 1..7: d[i] = q[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- State machine, evaluated only on strobes:
  - **SEARCH** (reset state). Control window: ctrl_run++. When ctrl_run reaches LOCK_COUNT, go to LOCKED and clear gap_ctr. Non-control window: ctrl_run←0 and offset←(offset+1) mod 10. The 9→0 wrap is legal; symbols lost around the wrap are discarded.
  - **LOCKED**. Offset is frozen. Control window: gap_ctr←0. Non-control window: gap_ctr++. When gap_ctr would exceed MAX_GAP, go to SEARCH, set ctrl_run←0, and leave offset unchanged.
- ctrl_run saturates at LOCK_COUNT. gap_ctr is wide enough for MAX_GAP+1 with no wrap.
- In SEARCH, sym_valid stays 0. The other data outputs may update but carry no meaning.

## Timing
- Reset values:
  - sym_valid=0, sym_raw=0, is_ctrl=0, ctrl=0, data=0, locked=0, offset=0.
  - phase=0, hist=0, ctrl_run=0, gap_ctr=0, state SEARCH.
- All outputs are registered. On a strobe edge, sym_raw, is_ctrl, ctrl, data and sym_valid update from `win`. sym_valid is high for exactly the one following cycle.
- Latency: a bit arriving on din reaches sym_raw no later than 15 cycles later; the exact value depends on phase and offset.
- locked rises on the same edge that registers the LOCK_COUNT-th control symbol. That symbol is emitted with sym_valid=1.
- locked falls on the edge of the (MAX_GAP+1)-th consecutive non-control symbol. No sym_valid pulse accompanies that symbol.
- Minimum sym_valid spacing is 5 cycles; there are no back-to-back pulses.
- Asynchronous reset mid-operation immediately returns every output to its reset value. Acquisition restarts from offset 0.

## Test plan
- **Reset:** hold rst_n_bit=0, toggle din randomly → all outputs 0. After release, sym_valid stays 0 until lock.
- **Acquisition:** stream repeated 0x354 with k=0..9 leading junk bits (ten runs) → locked=1 within 10+LOCK_COUNT symbols. Then sym_valid every 5 cycles with is_ctrl=1, ctrl=00, and offset constant afterwards.
- **Decode:** after lock, send 0x100, 0x3FF, 0x1FF, 0x0AB, 0x2AB → data 0x00, 0x00, 0x01, then ctrl=01 and ctrl=11 with is_ctrl set on the control symbols only.
- **Loss of lock:** after lock, send MAX_GAP data symbols then one control → lock held. Then send MAX_GAP+1 data symbols → locked falls on the last one with no sym_valid, and offset is unchanged.
- **Slip and wrap:** in SEARCH, force 10 consecutive non-control windows → offset steps 1,2,…,9,0 at one step per strobe. The strobe cadence stays at exactly 5 cycles.
- **Reset mid-lock:** pulse rst_n_bit low for 1 cycle while locked → all outputs are 0 asynchronously, and re-lock occurs on the next LOCK_COUNT aligned control symbols.
